// File: rtl/smvm_vector_arbiter.sv
// Round-robin arbiter sharing one single-port x-vector RAM among CISR channels.
// Same-address requests in a grant cycle are coalesced onto one RAM read.
module smvm_vector_arbiter #(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_CHANNELS-1:0]        req_valid,
  input  logic [NUM_CHANNELS*ADDR_W-1:0] req_addr,
  output logic [NUM_CHANNELS-1:0]        req_ready,
  output logic                           mem_rd_en,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic [DATA_W-1:0]              mem_rd_data,
  output logic [NUM_CHANNELS-1:0]        rsp_valid,
  output logic [NUM_CHANNELS*DATA_W-1:0] rsp_data,
  input  logic [NUM_CHANNELS-1:0]        rsp_ready,
  output logic [31:0]                    reads_issued,
  output logic [31:0]                    reads_coalesced
);

  localparam int PTR_W = $clog2(NUM_CHANNELS);

  logic [NUM_CHANNELS-1:0] pend;
  logic [NUM_CHANNELS-1:0] hold_full;
  logic [NUM_CHANNELS-1:0] eligible;
  logic [NUM_CHANNELS-1:0] grant;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        winner;
  logic                    found;
  logic [ADDR_W-1:0]       win_addr;
  logic [31:0]             grant_cnt;
  logic [ADDR_W-1:0]       addr_arr [NUM_CHANNELS];
  logic [DATA_W-1:0]       data_q   [NUM_CHANNELS];

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_flat
    assign addr_arr[g]                   = req_addr[g*ADDR_W +: ADDR_W];
    assign rsp_data[g*DATA_W +: DATA_W]  = data_q[g];
  end

  // Reset is folded into eligibility so grants are suppressed while rst is held.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      eligible[i] = req_valid[i] && !pend[i] && (!hold_full[i] || rsp_ready[i])
                    && !flush && !rst;
    end
  end

  // Scan order rr_ptr, rr_ptr+1, ...; PTR_W-bit addition wraps for power-of-two counts.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx    = '0;
    found  = 1'b0;
    winner = rr_ptr;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      idx = rr_ptr + PTR_W'(k);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign win_addr = addr_arr[winner];

  always_comb begin
    grant     = '0;
    grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      grant[i]  = found && eligible[i] && (addr_arr[i] == win_addr);
      grant_cnt = grant_cnt + 32'(grant[i]);
    end
  end

  assign req_ready = grant;
  assign mem_rd_en = found;
  assign mem_addr  = found ? win_addr : '0;
  assign rsp_valid = hold_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend            <= '0;
      hold_full       <= '0;
      rr_ptr          <= '0;
      reads_issued    <= '0;
      reads_coalesced <= '0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) data_q[i] <= '0;
    end else begin
      if (found) begin
        reads_issued    <= reads_issued + 32'd1;
        reads_coalesced <= reads_coalesced + grant_cnt - 32'd1;
      end
      if (flush) begin
        // Clearing pend here drops the RAM word returning this cycle.
        pend      <= '0;
        hold_full <= '0;
        rr_ptr    <= '0;
      end else begin
        if (found) rr_ptr <= winner + PTR_W'(1);
        // A granted channel is never pending, so pend simply tracks last cycle's grant.
        pend <= grant;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
          if (pend[i]) begin
            data_q[i]    <= mem_rd_data;
            hold_full[i] <= 1'b1;
          end else if (hold_full[i] && rsp_ready[i]) begin
            hold_full[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_smvm_vector_arbiter.sv
// Directed bench for smvm_vector_arbiter: inputs driven on the falling edge,
// outputs sampled 1 ns later; the RAM is a registered model of a fixed pattern.
module tb_smvm_vector_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] a [4];
  logic [63:0] req_addr;
  logic [3:0]  req_ready;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_rd_data = '0;
  logic [3:0]  rsp_valid;
  logic [127:0] rsp_data;
  logic [3:0]  rsp_ready = '0;
  logic [31:0] reads_issued;
  logic [31:0] reads_coalesced;

  int errors = 0;
  int checks = 0;

  assign req_addr = {a[3], a[2], a[1], a[0]};

  smvm_vector_arbiter #(.NUM_CHANNELS(4), .ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .reads_issued(reads_issued), .reads_coalesced(reads_coalesced)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram(input logic [15:0] addr);
    return {~addr, addr};
  endfunction

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram(mem_addr);

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; req_valid = '0; rsp_ready = '0;
    for (int i = 0; i < 4; i++) a[i] = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; rsp_ready = 4'b1111;
    a[0] = 16'd1; a[1] = 16'd2; a[2] = 16'd3; a[3] = 16'd4;
    @(negedge clk); #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", mem_rd_en); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    checks++; if (rsp_data !== 128'h0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    checks++; if (reads_issued !== 32'd0 || reads_coalesced !== 32'd0) begin
      errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", reads_issued, reads_coalesced); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_rdy [5];
    logic [15:0] exp_adr [5];
    exp_rdy[0] = 4'b0001; exp_rdy[1] = 4'b0010; exp_rdy[2] = 4'b0100; exp_rdy[3] = 4'b1000; exp_rdy[4] = 4'b0001;
    exp_adr[0] = 16'd10;  exp_adr[1] = 16'd20;  exp_adr[2] = 16'd30;  exp_adr[3] = 16'd40;  exp_adr[4] = 16'd10;
    do_reset();
    a[0] = 16'd10; a[1] = 16'd20; a[2] = 16'd30; a[3] = 16'd40;
    rsp_ready = 4'b1111; req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (req_ready !== exp_rdy[c] || mem_addr !== exp_adr[c] || mem_rd_en !== 1'b1) begin
        errors++; $display("FAIL rr_grant c=%0d got=%b/%0d exp=%b/%0d", c, req_ready, mem_addr, exp_rdy[c], exp_adr[c]); end
      if (c == 2) begin
        checks++; if (rsp_valid[0] !== 1'b1 || rsp_data[31:0] !== ram(16'd10)) begin
          errors++; $display("FAIL rr_data0 got=%b/%h exp=1/%h", rsp_valid[0], rsp_data[31:0], ram(16'd10)); end
      end
    end
    @(negedge clk); req_valid = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (reads_issued !== 32'd5 || reads_coalesced !== 32'd0) begin
      errors++; $display("FAIL rr_counters got=%0d/%0d exp=5/0", reads_issued, reads_coalesced); end
  endtask

  task automatic test_coalesce();
    do_reset();
    for (int i = 0; i < 4; i++) a[i] = 16'h55;
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b1111 || mem_rd_en !== 1'b1 || mem_addr !== 16'h55) begin
      errors++; $display("FAIL coal_grant got=%b/%b/%h exp=1111/1/0055", req_ready, mem_rd_en, mem_addr); end
    @(negedge clk); req_valid = '0; #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL coal_early_valid got=%b exp=0000", rsp_valid); end
    checks++; if (reads_issued !== 32'd1 || reads_coalesced !== 32'd3) begin
      errors++; $display("FAIL coal_counters got=%0d/%0d exp=1/3", reads_issued, reads_coalesced); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 4'b1111) begin errors++; $display("FAIL coal_valid got=%b exp=1111", rsp_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rsp_data[i*32 +: 32] !== ram(16'h55)) begin
        errors++; $display("FAIL coal_data ch=%0d got=%h exp=%h", i, rsp_data[i*32 +: 32], ram(16'h55)); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    a[1] = 16'h100; req_valid = 4'b0010; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_first_grant got=%b exp=0010", req_ready); end
    @(negedge clk); req_valid = '0;
    @(negedge clk); a[1] = 16'h101; req_valid = 4'b0010; #1;
    checks++; if (rsp_valid !== 4'b0010 || rsp_data[63:32] !== ram(16'h100)) begin
      errors++; $display("FAIL bp_held got=%b/%h exp=0010/%h", rsp_valid, rsp_data[63:32], ram(16'h100)); end
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      checks++; if (req_ready !== 4'b0000 || rsp_data[63:32] !== ram(16'h100)) begin
        errors++; $display("FAIL bp_stall c=%0d got=%b/%h exp=0000/%h", c, req_ready, rsp_data[63:32], ram(16'h100)); end
    end
    @(negedge clk); rsp_ready = 4'b0010; #1;
    checks++; if (req_ready !== 4'b0010 || mem_addr !== 16'h101) begin
      errors++; $display("FAIL bp_release got=%b/%h exp=0010/0101", req_ready, mem_addr); end
    @(negedge clk); req_valid = '0; rsp_ready = '0; #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL bp_consumed got=%b exp=0000", rsp_valid); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 4'b0010 || rsp_data[63:32] !== ram(16'h101)) begin
      errors++; $display("FAIL bp_new_data got=%b/%h exp=0010/%h", rsp_valid, rsp_data[63:32], ram(16'h101)); end
  endtask

  task automatic test_wrap();
    do_reset();
    rsp_ready = 4'b1111;
    a[2] = 16'h22; req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_setup got=%b exp=0100", req_ready); end
    @(negedge clk); req_valid = '0;
    repeat (2) @(negedge clk);
    a[0] = 16'h30; a[3] = 16'h33; req_valid = 4'b1001; #1;
    checks++; if (req_ready !== 4'b1000 || mem_addr !== 16'h33) begin
      errors++; $display("FAIL wrap_ch3 got=%b/%h exp=1000/0033", req_ready, mem_addr); end
    @(negedge clk); #1;
    checks++; if (req_ready !== 4'b0001 || mem_addr !== 16'h30) begin
      errors++; $display("FAIL wrap_ch0 got=%b/%h exp=0001/0030", req_ready, mem_addr); end
    @(negedge clk); req_valid = '0;
    repeat (2) @(negedge clk);
    a[1] = 16'h31; a[2] = 16'h32; req_valid = 4'b0111; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_ptr1 got=%b exp=0010", req_ready); end
  endtask

  task automatic test_flush();
    do_reset();
    rsp_ready = 4'b1111;
    a[2] = 16'h200; req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL flush_setup got=%b exp=0100", req_ready); end
    @(negedge clk);
    flush = 1'b1; a[0] = 16'h1; a[1] = 16'h2; a[3] = 16'h3; req_valid = 4'b1011; #1;
    checks++; if (req_ready !== 4'b0000 || mem_rd_en !== 1'b0) begin
      errors++; $display("FAIL flush_no_grant got=%b/%b exp=0000/0", req_ready, mem_rd_en); end
    @(negedge clk); flush = 1'b0; req_valid = '0; #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL flush_discard got=%b exp=0000", rsp_valid); end
    checks++; if (reads_issued !== 32'd1 || reads_coalesced !== 32'd0) begin
      errors++; $display("FAIL flush_counters got=%0d/%0d exp=1/0", reads_issued, reads_coalesced); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL flush_discard2 got=%b exp=0000", rsp_valid); end
    @(negedge clk); a[2] = 16'h4; req_valid = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL flush_ptr0 got=%b exp=0001", req_ready); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    rsp_ready = 4'b1111;
    a[0] = 16'h3f; a[1] = 16'h40; a[2] = 16'h41; a[3] = 16'h42;
    req_valid = 4'b0010; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_setup got=%b exp=0010", req_ready); end
    @(negedge clk); req_valid = 4'b1111; #1;
    rst = 1'b1; #1;
    checks++; if (req_ready !== 4'b0000 || mem_rd_en !== 1'b0 || mem_addr !== 16'h0) begin
      errors++; $display("FAIL mid_async_grant got=%b/%b/%h exp=0000/0/0000", req_ready, mem_rd_en, mem_addr); end
    checks++; if (rsp_valid !== 4'b0000 || reads_issued !== 32'd0) begin
      errors++; $display("FAIL mid_async_state got=%b/%0d exp=0000/0", rsp_valid, reads_issued); end
    @(negedge clk); rst = 1'b0; req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_no_rsp c=%0d got=%b exp=0000", c, rsp_valid); end
      @(negedge clk);
    end
    req_valid = 4'b0110; #1;
    checks++; if (req_ready !== 4'b0010 || mem_addr !== 16'h40) begin
      errors++; $display("FAIL mid_first_grant got=%b/%h exp=0010/0040", req_ready, mem_addr); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) a[i] = '0;
    test_reset();
    test_round_robin();
    test_coalesce();
    test_backpressure();
    test_wrap();
    test_flush();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/smvm_vector_arbiter.md
SMVM_VECTOR_ARBITER -- requirements
Module: smvm_vector_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_CHANNELS, 4, number of requesting CISR channels (power of two, 2..8); ADDR_W, 16, vector memory address width; DATA_W, 32, vector element width.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 flush  in  1  synchronous clear of all pending and held responses.
REQ-006 req_valid  in  NUM_CHANNELS  per-channel read request.
REQ-007 req_addr  in  NUM_CHANNELS x ADDR_W  per-channel column index (x-vector address).
REQ-008 req_ready  out  NUM_CHANNELS  per-channel grant; combinational.
REQ-009 mem_rd_en  out  1  single-port vector RAM read strobe.
REQ-010 mem_addr  out  ADDR_W  RAM read address.
REQ-011 mem_rd_data  in  DATA_W  RAM data, valid exactly 1 cycle after mem_rd_en.
REQ-012 rsp_valid  out  NUM_CHANNELS  per-channel response held.
REQ-013 rsp_data  out  NUM_CHANNELS x DATA_W  per-channel held x-vector element.
REQ-014 rsp_ready  in  NUM_CHANNELS  per-channel response consume.
REQ-015 reads_issued  out  32  count of mem_rd_en cycles.
REQ-016 reads_coalesced  out  32  count of grants served without their own RAM read.

Function
REQ-017 Per-channel state SHALL be pend[i] (read in flight) and hold_full[i] (response held); the arbiter itself SHALL track rr_ptr (log2 NUM_CHANNELS bits).
REQ-018 Channel i SHALL be eligible iff req_valid[i] && !pend[i] && (!hold_full[i] || rsp_ready[i]) && !flush.
REQ-019 Winner SHALL be the first eligible channel scanning rr_ptr, rr_ptr+1, ... modulo NUM_CHANNELS; no eligible channel -> no grant, mem_rd_en=0, rr_ptr unchanged.
REQ-020 On a grant, rr_ptr SHALL become (winner+1) mod NUM_CHANNELS at the next edge (wrap-around from NUM_CHANNELS-1 to 0).
REQ-021 Coalescing: every eligible channel whose req_addr equals the winner's req_addr SHALL also be granted in the same cycle; the grant mask SHALL drive req_ready.
REQ-022 Grant cycle T: mem_rd_en=1, mem_addr=winner req_addr, pend[g]<=1 for every granted g.
REQ-023 Cycle T+1: mem_rd_data SHALL be written into rsp_data[g] for every pend[g]; hold_full[g]<=1, pend[g]<=0; rsp_valid[g]=1 from cycle T+2.
REQ-024 rsp_valid[i] SHALL equal hold_full[i]; rsp_data[i] SHALL remain stable while rsp_valid[i]=1 and rsp_ready[i]=0.
REQ-025 rsp_valid[i] && rsp_ready[i] SHALL clear hold_full[i] at the edge, unless a write from REQ-023 occurs in the same cycle, in which case hold_full[i] stays 1 with new data.
REQ-026 Per-channel throughput SHALL be at most one grant per 2 cycles; aggregate at most one RAM read per cycle.
REQ-027 rsp_ready[i] while rsp_valid[i]=0 SHALL be ignored.
REQ-028 reads_issued SHALL increment by 1 per mem_rd_en cycle; reads_coalesced SHALL increment by (granted count - 1) per grant cycle; both SHALL wrap at 2^32.
REQ-029 flush=1 SHALL issue no grant, and at the next edge clear pend, hold_full and rr_ptr; RAM data returning in the following cycle SHALL be discarded; counters SHALL be preserved.

Reset
REQ-030 rst=1 SHALL immediately force pend=0, hold_full=0, rr_ptr=0, rsp_data=0, reads_issued=0, reads_coalesced=0; hence req_ready=0, mem_rd_en=0, mem_addr=0, rsp_valid=0.
REQ-031 Reset asserted mid-transfer SHALL discard any in-flight read; the first grant after deassertion SHALL go to the lowest eligible channel index.

Verification
REQ-032 After reset, req_valid=4'b1111, addrs 10/20/30/40, rsp_ready=1 -> grants ch0,1,2,3,0,... one per cycle, mem_addr 10,20,30,40; rsp_data[0]=RAM[10] at T+2.
REQ-033 All four request addr 0x55 same cycle -> single mem_rd_en, req_ready=4'b1111, reads_issued=1, reads_coalesced=3, all rsp_valid high 2 cycles later.
REQ-034 ch1 rsp_ready=0 with hold_full -> ch1 never granted, rsp_data[1] stable; raise rsp_ready -> ch1 granted that same cycle, new data 2 cycles later.
REQ-035 rr_ptr=3, only ch3 and ch0 requesting -> ch3 granted, then ch0 (wrap), rr_ptr back to 1.
REQ-036 flush one cycle after a grant to ch2 -> RAM return discarded, rsp_valid[2] stays 0, rr_ptr=0, counters unchanged.
REQ-037 rst pulsed between grant and data return -> all outputs 0 asynchronously, no rsp_valid afterward.
